// File: rtl/cve2_mem_arbiter.sv
// cve2_mem_arbiter: shares one OBI memory port between instruction fetch and LSU, routing responses back by source
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o,
  output logic        unexp_rvalid_o
);
  localparam int unsigned PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [PW-1:0] LAST = PW'(MaxOutstanding - 1);
  localparam logic [CW-1:0] MAX = CW'(MaxOutstanding);
  logic                      lock_q, lock_sel_q, rr_q, unexp_q;
  logic [MaxOutstanding-1:0] src_q;
  logic [PW-1:0]             wr_q, rd_q;
  logic [CW-1:0]             cnt_q;
  logic                      sel_data, full, hs, pop, head;
  // selection, payload mux, grant passthrough and response routing to the oldest outstanding source
  always_comb begin
    full           = cnt_q == MAX;
    sel_data       = lock_q ? lock_sel_q :
                     (instr_req_i ^ data_req_i) ? data_req_i :
                     (DataPriority ? 1'b1 : rr_q);
    mem_req_o      = rst_ni & ~full & (sel_data ? data_req_i : instr_req_i);
    hs             = mem_req_o & mem_gnt_i;
    instr_gnt_o    = hs & ~sel_data;
    data_gnt_o     = hs & sel_data;
    mem_we_o       = sel_data & data_we_i;
    mem_be_o       = sel_data ? data_be_i : 4'hF;
    mem_addr_o     = sel_data ? data_addr_i : instr_addr_i;
    mem_wdata_o    = sel_data ? data_wdata_i : 32'h0;
    pop            = rst_ni & mem_rvalid_i & (cnt_q != '0);
    head           = src_q[rd_q];
    instr_rvalid_o = pop & ~head;
    data_rvalid_o  = pop & head;
    instr_err_o    = instr_rvalid_o & mem_err_i;
    data_err_o     = data_rvalid_o & mem_err_i;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    busy_o         = (cnt_q != '0) | mem_req_o;
    unexp_rvalid_o = unexp_q;
  end
  // lock, round-robin pointer, source FIFO and outstanding count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      rr_q       <= 1'b0;
      unexp_q    <= 1'b0;
      src_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      lock_q     <= mem_req_o & ~mem_gnt_i;
      lock_sel_q <= sel_data;
      if (hs) begin
        rr_q        <= ~sel_data;
        src_q[wr_q] <= sel_data;
        wr_q        <= wr_q == LAST ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q == LAST ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(hs) - CW'(pop);
      if (mem_rvalid_i && cnt_q == '0) unexp_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// tb_cve2_mem_arbiter: two arbiters (data-priority and round-robin) checked every cycle against a source-queue model
module tb_cve2_mem_arbiter;
  localparam int MO = 2;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic        ireq[2], dreq[2], dwe[2], mgnt[2], mrv[2], merr[2];
  logic [3:0]  dbe[2];
  logic [31:0] iaddr[2], daddr[2], dwdata[2], mrdata[2];
  logic        igr[2], irv[2], ierr[2], dgr[2], drv[2], derr[2], mreq[2], mwe[2], busy[2], unexp[2];
  logic [31:0] irdata[2], drdata[2], maddr[2], mwdata[2];
  logic [3:0]  mbe[2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    cve2_mem_arbiter #(.MaxOutstanding(MO), .DataPriority(g == 0)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(ireq[g]), .instr_gnt_o(igr[g]), .instr_addr_i(iaddr[g]),
      .instr_rvalid_o(irv[g]), .instr_rdata_o(irdata[g]), .instr_err_o(ierr[g]),
      .data_req_i(dreq[g]), .data_gnt_o(dgr[g]), .data_we_i(dwe[g]), .data_be_i(dbe[g]),
      .data_addr_i(daddr[g]), .data_wdata_i(dwdata[g]),
      .data_rvalid_o(drv[g]), .data_rdata_o(drdata[g]), .data_err_o(derr[g]),
      .mem_req_o(mreq[g]), .mem_gnt_i(mgnt[g]), .mem_we_o(mwe[g]), .mem_be_o(mbe[g]),
      .mem_addr_o(maddr[g]), .mem_wdata_o(mwdata[g]),
      .mem_rvalid_i(mrv[g]), .mem_rdata_i(mrdata[g]), .mem_err_i(merr[g]),
      .busy_o(busy[g]), .unexp_rvalid_o(unexp[g])
    );
  end
  // model: pending side of a stalled request, last-granted side, and a shift register of sources in issue order
  bit          lockv[2], locks[2], rr[2], unexp_m[2], ig_prev[2], dg_prev[2];
  int          n[2];
  logic [31:0] pend[2];
  int          compared = 0, mismatched = 0;
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d] @%0t: got %h want %h", nm, k, $time, act, exp);
    end
  endtask
  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      bit full, sel, ereq, hs, pop, head;
      full = n[k] == MO;
      sel  = lockv[k] ? locks[k] : (ireq[k] != dreq[k]) ? dreq[k] : (k == 0 ? 1'b1 : rr[k]);
      ereq = rst_n && !full && (sel ? dreq[k] : ireq[k]);
      hs   = ereq && mgnt[k];
      pop  = rst_n && mrv[k] && n[k] > 0;
      head = pend[k][0];
      chk("mem_req", k, mreq[k], ereq);
      chk("instr_gnt", k, igr[k], hs && !sel);
      chk("data_gnt", k, dgr[k], hs && sel);
      chk("mem_we", k, mwe[k], sel && dwe[k]);
      chk("mem_be", k, mbe[k], sel ? dbe[k] : 4'hF);
      chk("mem_addr", k, maddr[k], sel ? daddr[k] : iaddr[k]);
      chk("mem_wdata", k, mwdata[k], sel ? dwdata[k] : 32'h0);
      chk("instr_rvalid", k, irv[k], pop && !head);
      chk("data_rvalid", k, drv[k], pop && head);
      chk("instr_err", k, ierr[k], pop && !head && merr[k]);
      chk("data_err", k, derr[k], pop && head && merr[k]);
      chk("instr_rdata", k, irdata[k], mrdata[k]);
      chk("data_rdata", k, drdata[k], mrdata[k]);
      chk("busy", k, busy[k], n[k] > 0 || ereq);
      chk("unexp", k, unexp[k], unexp_m[k]);
      ig_prev[k] = hs && !sel;
      dg_prev[k] = hs && sel;
      if (!rst_n) begin
        lockv[k] = 0; rr[k] = 0; unexp_m[k] = 0; n[k] = 0; pend[k] = 0;
      end else begin
        lockv[k] = ereq && !mgnt[k];
        locks[k] = sel;
        if (hs) rr[k] = !sel;
        if (mrv[k] && n[k] == 0) unexp_m[k] = 1;
        if (pop) begin pend[k] = pend[k] >> 1; n[k]--; end
        if (hs) begin pend[k] = pend[k] | (32'(sel) << n[k]); n[k]++; end
      end
    end
  endtask
  task automatic fin();
    model_check();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc();
    @(negedge clk);
    fin();
  endtask
  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      ireq[k] = 0; dreq[k] = 0; dwe[k] = 0; mgnt[k] = 0; mrv[k] = 0; merr[k] = 0;
      dbe[k] = 4'h0; iaddr[k] = 0; daddr[k] = 0; dwdata[k] = 0; mrdata[k] = 0;
    end
  endtask
  task automatic drain();
    for (int k = 0; k < 2; k++) begin ireq[k] = 0; dreq[k] = 0; mgnt[k] = 0; merr[k] = 0; end
    repeat (8) begin
      for (int k = 0; k < 2; k++) begin mrv[k] = n[k] > 0; mrdata[k] = $urandom; end
      cyc();
    end
    for (int k = 0; k < 2; k++) mrv[k] = 0;
  endtask
  initial begin
    idle();
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin ireq[k] = 1; dreq[k] = 1; mgnt[k] = 1; end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mem_req", 0, mreq[0], 0);
    chk("rst_instr_gnt", 0, igr[0], 0);
    chk("rst_data_gnt", 0, dgr[0], 0);
    chk("rst_busy", 0, busy[0], 0);
    fin();
    rst_n = 1;
    ireq[1] = 0; dreq[1] = 0;
    @(negedge clk);
    chk("tie_prio_data", 0, dgr[0], 1);
    chk("tie_prio_instr", 0, igr[0], 0);
    fin();
    drain();
    ireq[1] = 1; dreq[1] = 1; mgnt[1] = 1; iaddr[1] = 32'h1000; daddr[1] = 32'h2000;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin ireq[1] = 0; dreq[1] = 0; end
      mrv[1] = c > 0; mrdata[1] = 32'(c);
      @(negedge clk);
      if (c < 4) begin
        chk("rr_instr_gnt", 1, igr[1], c % 2 == 0);
        chk("rr_data_gnt", 1, dgr[1], c % 2 == 1);
      end
      if (c > 0) begin
        chk("rr_instr_rv", 1, irv[1], c % 2 == 1);
        chk("rr_data_rv", 1, drv[1], c % 2 == 0);
      end
      fin();
    end
    drain();
    dreq[0] = 1; daddr[0] = 32'h100; iaddr[0] = 32'h200;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) ireq[0] = 1;
      mgnt[0] = c == 3;
      @(negedge clk);
      chk("lock_addr", 0, maddr[0], 32'h100);
      chk("lock_dgnt", 0, dgr[0], c == 3);
      chk("lock_ignt", 0, igr[0], 0);
      fin();
    end
    dreq[0] = 0;
    @(negedge clk);
    chk("after_lock_ignt", 0, igr[0], 1);
    chk("after_lock_addr", 0, maddr[0], 32'h200);
    fin();
    drain();
    ireq[0] = 1; iaddr[0] = 32'h300;
    cyc();
    dreq[0] = 1; daddr[0] = 32'h400;
    @(negedge clk);
    chk("ilock_addr", 0, maddr[0], 32'h300);
    chk("ilock_dgnt", 0, dgr[0], 0);
    fin();
    mgnt[0] = 1;
    @(negedge clk);
    chk("ilock_ignt", 0, igr[0], 1);
    fin();
    ireq[0] = 0;
    @(negedge clk);
    chk("ilock_next_dgnt", 0, dgr[0], 1);
    chk("ilock_next_addr", 0, maddr[0], 32'h400);
    fin();
    drain();
    dreq[0] = 1; mgnt[0] = 1; daddr[0] = 32'h600;
    for (int c = 0; c < 7; c++) begin
      mrv[0] = c == 3 || c == 4;
      @(negedge clk);
      chk("full_dgnt", 0, dgr[0], c < 2 || c == 4 || c == 5);
      chk("full_req", 0, mreq[0], c < 2 || c == 4 || c == 5);
      if (c == 2) chk("full_busy", 0, busy[0], 1);
      if (c == 3) chk("full_pop_rv", 0, drv[0], 1);
      fin();
    end
    drain();
    dreq[0] = 1; dwe[0] = 0; dbe[0] = 4'hF; daddr[0] = 32'h500; mgnt[0] = 1;
    cyc();
    dreq[0] = 0; mrv[0] = 1; merr[0] = 1; mrdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("err_drv", 0, drv[0], 1);
    chk("err_derr", 0, derr[0], 1);
    chk("err_rdata", 0, drdata[0], 32'hDEADBEEF);
    chk("err_irv", 0, irv[0], 0);
    fin();
    drain();
    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        if (!ireq[k] || ig_prev[k]) begin ireq[k] = $urandom_range(0, 2) != 0; iaddr[k] = $urandom; end
        if (!dreq[k] || dg_prev[k]) begin
          dreq[k] = $urandom_range(0, 2) != 0; dwe[k] = $urandom_range(0, 1) == 1;
          dbe[k] = 4'($urandom); daddr[k] = $urandom; dwdata[k] = $urandom;
        end
        mgnt[k] = $urandom_range(0, 3) != 0;
        mrv[k] = n[k] > 0 && $urandom_range(0, 1) == 1;
        mrdata[k] = $urandom;
        merr[k] = $urandom_range(0, 3) == 0;
      end
      cyc();
    end
    drain();
    mrv[0] = 1;
    @(negedge clk);
    chk("spur_irv", 0, irv[0], 0);
    chk("spur_drv", 0, drv[0], 0);
    fin();
    mrv[0] = 0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_sticky", 0, unexp[0], 1);
      fin();
    end
    rst_n = 0;
    cyc();
    rst_n = 1;
    @(negedge clk);
    chk("spur_cleared", 0, unexp[0], 0);
    fin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
